pet_action_ctrl: RTL and testbench

- Sequences timed pet actions (eat, sleep, game) requested by the navigation FSM.
- Maintains the three pet stats: hunger, energy and happiness.
- Returns `doneAction` to the navigation FSM when an action completes, and asserts `gameEnd` when any stat drains to zero.
- Sits beside navigation, driven by its `transition`/`location`/`action` outputs; stats feed the display/HUD logic.

---
 rtl/veridog_pkg.sv | 36 +++
 rtl/pet_action_ctrl_if.sv | 24 ++
 rtl/tick_divider.sv | 33 +++
 rtl/pet_action_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pet_action_ctrl.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/veridog_pkg.sv
// Shared codes, action kinds and FSM encoding for the pet action controller.
package veridog_pkg;

  localparam logic [7:0] CODE_EAT   = 8'h11;
  localparam logic [7:0] CODE_SLEEP = 8'h12;
  localparam logic [7:0] CODE_GAME  = 8'h33;
  localparam logic [7:0] CODE_NONE  = 8'hFF;

  localparam int unsigned STAT_W_DEF = 7;

  typedef enum logic [1:0] {
    KIND_NONE,
    KIND_EAT,
    KIND_SLEEP,
    KIND_GAME
  } kind_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE,
    ST_DEAD
  } state_t;

  // A request only counts while navigation is not in its wait state.
  function automatic kind_t decode_req(input logic transition, input logic [7:0] code);
    if (transition) return KIND_NONE;
    case (code)
      CODE_EAT:   return KIND_EAT;
      CODE_SLEEP: return KIND_SLEEP;
      CODE_GAME:  return KIND_GAME;
      default:    return KIND_NONE;
    endcase
  endfunction

endpackage

// File: rtl/pet_action_ctrl_if.sv
// Navigation-to-action-controller bundle: request nibbles in, status and stats out.
interface pet_action_ctrl_if #(
  parameter int unsigned STAT_W = veridog_pkg::STAT_W_DEF
);
  logic              transition;
  logic [3:0]        location;
  logic [3:0]        action;
  logic              doneAction;
  logic              gameEnd;
  logic              busy;
  logic [STAT_W-1:0] hunger;
  logic [STAT_W-1:0] energy;
  logic [STAT_W-1:0] happiness;

  modport master (
    output transition, location, action,
    input  doneAction, gameEnd, busy, hunger, energy, happiness
  );

  modport slave (
    input  transition, location, action,
    output doneAction, gameEnd, busy, hunger, energy, happiness
  );
endinterface

// File: rtl/tick_divider.sv
// Game-tick pulse generator; PET_FAST_TICK_EN replaces the divider with a tick every cycle.
module tick_divider #(
  parameter int unsigned TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic resetn,
  output logic tick
);

`ifdef PET_FAST_TICK_EN
  logic unused_ok;
  assign unused_ok = ^{clk, resetn, 32'(TICK_DIV)};
  assign tick      = 1'b1;
`else
  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/pet_action_ctrl.sv
// Timed eat/sleep/game sequencer and pet stat keeper (tick source honours PET_FAST_TICK_EN).
module pet_action_ctrl
  import veridog_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 25000000,
  parameter int unsigned STAT_W      = STAT_W_DEF,
  parameter int unsigned STAT_MAX    = 100,
  parameter int unsigned STAT_INIT   = 50,
  parameter int unsigned EAT_TICKS   = 4,
  parameter int unsigned EAT_GAIN    = 10,
  parameter int unsigned SLEEP_TICKS = 8,
  parameter int unsigned SLEEP_GAIN  = 5,
  parameter int unsigned GAME_TICKS  = 6,
  parameter int unsigned GAME_GAIN   = 8,
  parameter int unsigned GAME_COST   = 2,
  parameter int unsigned DECAY_TICKS = 10
) (
  input  logic           clk,
  input  logic           resetn,
  pet_action_ctrl_if.slave bus
);

  localparam int unsigned DUR_W = 8;
  localparam int unsigned DEC_W = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECAY_TICKS - 1);

  logic              tick;
  kind_t             req_kind;
  kind_t             kind;
  state_t            state;
  logic [DUR_W-1:0]  dur;
  logic [DEC_W-1:0]  decay_cnt;
  logic [STAT_W-1:0] hunger_q, energy_q, happy_q;
  logic [STAT_W-1:0] hunger_nx, energy_nx, happy_nx;
  logic              done_q, end_q, busy_q;
  logic              act, decay, upd_en, stat_zero;
  int unsigned       h_gain, e_gain, e_cost, p_gain;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .tick   (tick)
  );

  function automatic logic [DUR_W-1:0] ticks_of(input kind_t k);
    case (k)
      KIND_EAT:   return DUR_W'(EAT_TICKS);
      KIND_SLEEP: return DUR_W'(SLEEP_TICKS);
      KIND_GAME:  return DUR_W'(GAME_TICKS);
      default:    return '0;
    endcase
  endfunction

  // Gain, cost and decay fold into one signed sum so a single clamp covers all cases.
  function automatic logic [STAT_W-1:0] upd_stat(input logic [STAT_W-1:0] s,
                                                 input int unsigned gain,
                                                 input int unsigned cost,
                                                 input logic dec);
    int v;
    v = int'(s) + int'(gain) - int'(cost) - int'(dec);
    if (v <= 0)                 return '0;
    else if (v >= int'(STAT_MAX)) return STAT_W'(STAT_MAX);
    else                        return STAT_W'(v);
  endfunction

  always_comb begin
    req_kind = decode_req(bus.transition, {bus.location, bus.action});
    act      = (state == ST_RUN) && tick && (req_kind == kind);
    decay    = tick && (decay_cnt == DEC_LAST) && (state != ST_DEAD);
    h_gain   = 0;
    e_gain   = 0;
    e_cost   = 0;
    p_gain   = 0;
    if (act) begin
      case (kind)
        KIND_EAT:   h_gain = EAT_GAIN;
        KIND_SLEEP: e_gain = SLEEP_GAIN;
        KIND_GAME: begin
          p_gain = GAME_GAIN;
          e_cost = GAME_COST;
        end
        default: ;
      endcase
    end
    hunger_nx = upd_stat(hunger_q, h_gain, 0, decay);
    energy_nx = upd_stat(energy_q, e_gain, e_cost, decay);
    happy_nx  = upd_stat(happy_q, p_gain, 0, decay);
    upd_en    = act || decay;
    stat_zero = upd_en && ((hunger_nx == '0) || (energy_nx == '0) || (happy_nx == '0));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      kind      <= KIND_NONE;
      dur       <= '0;
      decay_cnt <= '0;
      hunger_q  <= STAT_W'(STAT_INIT);
      energy_q  <= STAT_W'(STAT_INIT);
      happy_q   <= STAT_W'(STAT_INIT);
      done_q    <= 1'b0;
      end_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      if (tick && (state != ST_DEAD)) begin
        decay_cnt <= (decay_cnt == DEC_LAST) ? '0 : decay_cnt + 1'b1;
      end
      if (upd_en) begin
        hunger_q <= hunger_nx;
        energy_q <= energy_nx;
        happy_q  <= happy_nx;
      end
      if (stat_zero) begin
        state  <= ST_DEAD;
        end_q  <= 1'b1;
        busy_q <= 1'b0;
        done_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (req_kind != KIND_NONE) begin
              kind   <= req_kind;
              dur    <= ticks_of(req_kind);
              state  <= ST_RUN;
              busy_q <= 1'b1;
            end
          end
          ST_RUN: begin
            // A dropped or changed request wins over a coincident tick: no effect applied.
            if (req_kind != kind) begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
            end else if (tick) begin
              dur <= dur - 1'b1;
              if (dur == DUR_W'(1)) begin
                state  <= ST_DONE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            if (req_kind != kind) begin
              state  <= ST_IDLE;
              done_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.doneAction = done_q;
  assign bus.gameEnd    = end_q;
  assign bus.busy       = busy_q;
  assign bus.hunger     = hunger_q;
  assign bus.energy     = energy_q;
  assign bus.happiness  = happy_q;

endmodule

// File: tb/tb_pet_action_ctrl.sv
// Directed bench for pet_action_ctrl: action sequencing, clamping, abort, death, decay and async reset.
module tb_pet_action_ctrl;

  logic clk;
  logic resetn_a;
  logic resetn_b;
  int   n_assert;
  int   n_fail;

  pet_action_ctrl_if #(.STAT_W(7)) bus_a ();
  pet_action_ctrl_if #(.STAT_W(7)) bus_b ();

  pet_action_ctrl #(.TICK_DIV(1), .STAT_W(7), .DECAY_TICKS(1000)) dut_a (
    .clk    (clk),
    .resetn (resetn_a),
    .bus    (bus_a)
  );

  pet_action_ctrl #(.TICK_DIV(1), .STAT_W(7), .DECAY_TICKS(3)) dut_b (
    .clk    (clk),
    .resetn (resetn_b),
    .bus    (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic req_a(input logic t, input logic [7:0] code);
    bus_a.transition = t;
    bus_a.location   = code[7:4];
    bus_a.action     = code[3:0];
  endtask

  task automatic req_b(input logic t, input logic [7:0] code);
    bus_b.transition = t;
    bus_b.location   = code[7:4];
    bus_b.action     = code[3:0];
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    resetn_a = 1'b0;
    resetn_b = 1'b0;
    req_a(1'b1, 8'h00);
    req_b(1'b1, 8'h00);
    #12;
    resetn_a = 1'b1;

    // Reset state after idling
    step(20);
    chk("rst_hunger", bus_a.hunger, 50);
    chk("rst_energy", bus_a.energy, 50);
    chk("rst_happy", bus_a.happiness, 50);
    chk("rst_done", bus_a.doneAction, 0);
    chk("rst_end", bus_a.gameEnd, 0);
    chk("rst_busy", bus_a.busy, 0);

    // EAT held: busy for 4 cycles, hunger +10 per tick, done afterwards
    req_a(1'b0, 8'h11);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("eat_busy", bus_a.busy, 1);
      chk("eat_hunger", bus_a.hunger, 8'(50 + 10 * i));
      chk("eat_done_low", bus_a.doneAction, 0);
    end
    step(1);
    chk("eat_done", bus_a.doneAction, 1);
    chk("eat_busy_end", bus_a.busy, 0);
    chk("eat_hunger_end", bus_a.hunger, 90);
    step(2);
    chk("eat_done_hold", bus_a.doneAction, 1);
    chk("eat_hunger_hold", bus_a.hunger, 90);
    req_a(1'b1, 8'h10);
    step(1);
    chk("eat_done_drop", bus_a.doneAction, 0);

    // EAT from 90: clamps at 100
    req_a(1'b0, 8'h11);
    step(1);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("clamp_hunger", bus_a.hunger, 100);
    end
    chk("clamp_done", bus_a.doneAction, 1);
    req_a(1'b1, 8'h00);
    step(1);
    chk("clamp_done_drop", bus_a.doneAction, 0);

    // GAME aborted after 2 ticks
    req_a(1'b0, 8'h33);
    step(3);
    chk("abort_energy_pre", bus_a.energy, 46);
    chk("abort_happy_pre", bus_a.happiness, 66);
    req_a(1'b0, 8'h10);
    step(1);
    chk("abort_busy", bus_a.busy, 0);
    chk("abort_done", bus_a.doneAction, 0);
    step(3);
    chk("abort_energy", bus_a.energy, 46);
    chk("abort_happy", bus_a.happiness, 66);
    chk("abort_done_idle", bus_a.doneAction, 0);

    // Three full games drain energy by 12 each
    for (int g = 0; g < 3; g++) begin
      req_a(1'b0, 8'h33);
      step(7);
      chk("game_done", bus_a.doneAction, 1);
      chk("game_energy", bus_a.energy, 8'(34 - 12 * g));
      req_a(1'b1, 8'h33);
      step(1);
    end
    chk("game_happy_sat", bus_a.happiness, 100);

    // Partial game down to energy 2
    req_a(1'b0, 8'h33);
    step(5);
    chk("part_energy", bus_a.energy, 2);
    chk("part_busy", bus_a.busy, 1);
    req_a(1'b1, 8'h00);
    step(1);
    chk("part_idle", bus_a.busy, 0);

    // GAME at energy 2: first tick drains to 0 and the pet dies
    req_a(1'b0, 8'h33);
    step(1);
    chk("dead_run_busy", bus_a.busy, 1);
    chk("dead_end_pre", bus_a.gameEnd, 0);
    step(1);
    chk("dead_energy", bus_a.energy, 0);
    chk("dead_end", bus_a.gameEnd, 1);
    chk("dead_busy", bus_a.busy, 0);
    req_a(1'b0, 8'h11);
    step(10);
    chk("dead_ignore_busy", bus_a.busy, 0);
    chk("dead_freeze_hunger", bus_a.hunger, 100);
    chk("dead_freeze_energy", bus_a.energy, 0);
    chk("dead_freeze_happy", bus_a.happiness, 100);
    chk("dead_sticky", bus_a.gameEnd, 1);
    chk("dead_done", bus_a.doneAction, 0);

    // Decay every 3 ticks on the second instance
    resetn_b = 1'b1;
    step(2);
    chk("decay_hold", bus_b.hunger, 50);
    step(1);
    chk("decay_h1", bus_b.hunger, 49);
    chk("decay_e1", bus_b.energy, 49);
    chk("decay_p1", bus_b.happiness, 49);
    step(2);
    chk("decay_hold2", bus_b.energy, 49);
    step(1);
    chk("decay_e2", bus_b.energy, 48);

    // Eat tick coinciding with decay: single combined update
    req_b(1'b0, 8'h11);
    step(2);
    chk("mix_hunger1", bus_b.hunger, 58);
    step(1);
    chk("mix_hunger2", bus_b.hunger, 67);
    chk("mix_energy", bus_b.energy, 47);
    chk("mix_happy", bus_b.happiness, 47);
    chk("mix_busy", bus_b.busy, 1);

    // Asynchronous reset mid-RUN
    #2;
    resetn_b = 1'b0;
    #1;
    chk("areset_busy", bus_b.busy, 0);
    chk("areset_hunger", bus_b.hunger, 50);
    chk("areset_energy", bus_b.energy, 50);
    chk("areset_done", bus_b.doneAction, 0);
    chk("areset_end", bus_b.gameEnd, 0);
    step(1);
    resetn_b = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
